// File: rtl/lfsr_arb.sv
// Shared Fibonacci LFSR served to NREQ requesters through a round-robin arbiter.
// Define LFSR_ARB_FIXED_PRIO_EN to select fixed (lowest-index-wins) priority.
module lfsr_arb #(
  parameter int unsigned      WIDTH = 4,
  parameter int unsigned      NREQ  = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'b0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_out,
  output logic             wrap
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] seed_eff;
  logic [IW-1:0]    winner;
  logic             any_req;

  assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};
  // An all-zero seed would lock the LFSR up, so it is replaced by SEED.
  assign seed_eff   = (seed_in == '0) ? SEED : seed_in;
  assign any_req    = |req;

`ifdef LFSR_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      if (req[IW'(i - 1)]) winner = IW'(i - 1);
    end
  end
`else
  logic [IW-1:0] last_gnt;
  logic          found;
  int unsigned   idx;

  // Search starts one past the last winner and wraps modulo NREQ.
  always_comb begin
    winner = last_gnt;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_gnt) + i) % NREQ;
      if (!found && req[IW'(idx)]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt <= IW'(NREQ - 1);
    end else if (!seed_load && any_req) begin
      last_gnt <= winner;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SEED;
      seed_reg  <= SEED;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_out   <= '0;
      wrap      <= 1'b0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      wrap      <= 1'b0;
      if (seed_load) begin
        state    <= seed_eff;
        seed_reg <= seed_eff;
      end else if (any_req) begin
        state     <= next_state;
        gnt       <= NREQ'(1) << winner;
        rnd_valid <= 1'b1;
        rnd_out   <= next_state;
        wrap      <= (next_state == seed_reg);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_arb.sv
// Bench for lfsr_arb: directed vector table plus randomized traffic against a reference model.
module tb_lfsr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load;
  logic [3:0] seed_in;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       rnd_valid;
  logic [3:0] rnd_out;
  logic       wrap;

  int n_vec = 0;
  int n_err = 0;

  lfsr_arb #(.WIDTH(4), .NREQ(4), .TAPS(4'b1100), .SEED(4'b0001)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .gnt(gnt), .rnd_valid(rnd_valid), .rnd_out(rnd_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] sd;
    logic [3:0] rq;
    logic [3:0] gnt;
    logic       valid;
    logic [3:0] rnd;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  int unsigned m_state, m_seed, m_last;
  int unsigned e_gnt, e_valid, e_rnd, e_wrap;

  function automatic int unsigned lfsr_next(input int unsigned s);
    int unsigned ones = 0;
    for (int b = 0; b < 4; b++)
      if (((12 >> b) % 2 == 1) && ((s >> b) % 2 == 1)) ones++;
    return ((s * 2) % 16) + (ones % 2);
  endfunction

  function automatic int unsigned pick(input logic [3:0] rq, input int unsigned last);
`ifdef LFSR_ARB_FIXED_PRIO_EN
    for (int unsigned c = 0; c < 4; c++) if (rq[c]) return c;
`else
    for (int unsigned k = 1; k <= 4; k++) if (rq[(last + k) % 4]) return (last + k) % 4;
`endif
    return 0;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic ld, input logic [3:0] sd, input logic [3:0] rq);
    int unsigned w;
    rst = r; seed_load = ld; seed_in = sd; req = rq;
    if (!r) begin
      m_state = 1; m_seed = 1; m_last = 3;
      e_gnt = 0; e_valid = 0; e_rnd = 0; e_wrap = 0;
    end else begin
      e_gnt = 0; e_valid = 0; e_wrap = 0;
      if (ld) begin
        m_state = (sd == 0) ? 1 : 32'(sd);
        m_seed  = m_state;
      end else if (rq != 0) begin
        w       = pick(rq, m_last);
        m_last  = w;
        m_state = lfsr_next(m_state);
        e_gnt   = 1 << w;
        e_valid = 1;
        e_rnd   = m_state;
        e_wrap  = (m_state == m_seed) ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    check("model_gnt",   32'(gnt),       e_gnt);
    check("model_valid", 32'(rnd_valid), e_valid);
    check("model_rnd",   32'(rnd_out),   e_rnd);
    check("model_wrap",  32'(wrap),      e_wrap);
  endtask

  function automatic vec_t mk(input logic r, input logic ld, input logic [3:0] sd, input logic [3:0] rq,
                              input logic [3:0] g, input logic v, input logic [3:0] rn, input logic wr);
    vec_t t;
    t.rst = r; t.ld = ld; t.sd = sd; t.rq = rq;
    t.gnt = g; t.valid = v; t.rnd = rn; t.wrap = wr;
    return t;
  endfunction

  logic [3:0] seq [15];
  logic [3:0] rr_gnt [4];

  initial begin
    rst = 1'b0; seed_load = 1'b0; seed_in = '0; req = '0;
    seq = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
            4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
`ifdef LFSR_ARB_FIXED_PRIO_EN
    rr_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif

    // reset, then one requester walks the whole period
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0));
    for (int k = 0; k < 15; k++)
      tbl.push_back(mk(1, 0, 4'h0, 4'b0001, 4'b0001, 1, seq[k], k == 14));
    // all requesters held high after reset
    tbl.push_back(mk(0, 0, 4'h0, 4'b1111, 4'h0, 0, 4'h0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 0, 4'h0, 4'b1111, rr_gnt[k % 4], 1, seq[k], 0));
    // reset mid-stream, then first grant to req[0]
    tbl.push_back(mk(0, 0, 4'h0, 4'b1111, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 4'b1111, 4'b0001, 1, 4'b0010, 0));
    // seed load with coincident request: load wins
    tbl.push_back(mk(1, 1, 4'b1001, 4'b0010, 4'h0, 0, 4'b0010, 0));
    for (int k = 0; k < 15; k++)
      tbl.push_back(mk(1, 0, 4'h0, 4'b0010, 4'b0010, 1, seq[(3 + k) % 15], k == 14));
    // idle gap, then the sequence continues without a skip
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 0, 4'h0, 4'h0, 4'h0, 0, 4'b1001, 0));
    tbl.push_back(mk(1, 0, 4'h0, 4'b0100, 4'b0100, 1, 4'b0011, 0));
    // zero seed is substituted by SEED
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, 4'h0, 0, 4'b0011, 0));
    tbl.push_back(mk(1, 0, 4'h0, 4'b1000, 4'b1000, 1, 4'b0010, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].ld, tbl[i].sd, tbl[i].rq);
      check($sformatf("vec%0d_gnt", i),   32'(gnt),       32'(tbl[i].gnt));
      check($sformatf("vec%0d_valid", i), 32'(rnd_valid), 32'(tbl[i].valid));
      check($sformatf("vec%0d_rnd", i),   32'(rnd_out),   32'(tbl[i].rnd));
      check($sformatf("vec%0d_wrap", i),  32'(wrap),      32'(tbl[i].wrap));
    end

    // randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      logic       r, ld;
      logic [3:0] sd, rq;
      r  = ($urandom % 64) != 0;
      ld = ($urandom % 12) == 0;
      sd = (($urandom % 4) == 0) ? 4'h0 : 4'($urandom);
      rq = (($urandom % 5) == 0) ? 4'h0 : 4'($urandom);
      apply(r, ld, sd, rq);
      if (rnd_valid) check("rnd_nonzero", 32'(rnd_out != 4'h0), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_arb.md
# lfsr_arb

Shared random-number source: one Fibonacci LFSR time-multiplexed among NREQ requesters by a round-robin arbiter. Each granted request advances the LFSR by exactly one step and returns the new value to the winner. The block also handles seed loading with lock-up protection and flags completion of a full sequence period. It sits between the LFSR datapath and the blocks that consume pseudo-random words (test-pattern generators, scramblers, back-off timers).

## Interface
- WIDTH, 4, LFSR state width (≥ 3)
- NREQ, 4, number of requesters (2..8)
- TAPS, 4'b1100, feedback tap mask (bit i set → state[i] in XOR); default gives x^4+x^3+1, maximal length
- SEED, 4'b0001, reset seed; also the substitute for an all-zero seed_in

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- seed_load  in  1  load seed_in into LFSR this cycle
- seed_in  in  WIDTH  seed value
- req  in  NREQ  per-requester request, level, held until granted
- gnt  out  NREQ  one-hot grant, registered, 1-cycle pulse
- rnd_valid  out  1  rnd_out valid, coincident with gnt
- rnd_out  out  WIDTH  LFSR value delivered to the granted requester
- wrap  out  1  1-cycle pulse: delivered value equals current seed (period complete)

## Operation
- LFSR step: next = {state[WIDTH-2:0], ^(state & TAPS)}.
- Per cycle, priority order:
  1. rst low: reset.
  2. seed_load high: load seed.
  3. otherwise, if any req bit is set: grant.
- Seed: state ← seed_in; if seed_in == 0, state ← SEED instead (the all-zero lock-up state is never loaded). The loaded value is kept in seed_reg. No grant is issued in a load cycle; pending req is serviced on the following cycle.
- Grant: pick one requester, advance state one step, register gnt = one-hot(winner), rnd_out = next, rnd_valid = 1. wrap = 1 when next == seed_reg.
- Round-robin: search starts at last_gnt+1 modulo NREQ; last_gnt updates to the winner. Arbiter holds no state beyond last_gnt.
- No request: state holds; gnt = 0, rnd_valid = 0, wrap = 0; rnd_out holds its last value.
- The requester samples rnd_out in the cycle its gnt bit is high, and must drop req in the next cycle if it wants only one word. A req still high in the gnt cycle is eligible again (one word per grant).

## Timing
- Reset values:
  - state = SEED, seed_reg = SEED, last_gnt = NREQ-1 (req[0] wins first)
  - gnt = 0, rnd_valid = 0, rnd_out = 0, wrap = 0
- Latency: req sampled high at edge N → gnt/rnd_valid/rnd_out valid after edge N (1 cycle).
- Throughput: one word per cycle aggregate. With all NREQ requests held high, each requester is granted once every NREQ cycles.
- Period: with a maximal TAPS, wrap pulses on every (2^WIDTH − 1)-th grant after a seed load or reset.
- seed_load and req in the same cycle: the load wins, and gnt = 0 that cycle.
- Reset mid-stream: clears gnt and rnd_valid at that edge. No partial grant survives.
- Asynchronous req glitches are not permitted; req must be synchronous to clk.

## Configuration
- LFSR_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest-index asserted req always wins, and last_gnt is not implemented.
- LFSR_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
- The LFSR, seed and wrap behaviour are identical in both builds.

## Test plan
- Reset then req=4'b0001 held for 15 cycles → rnd_out sequence: 0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001; wrap=1 only on the 15th (0001).
- req=4'b1111 held for 8 cycles after reset → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; rnd_out as above. Same stimulus with LFSR_ARB_FIXED_PRIO_EN → gnt=0001 every cycle.
- seed_load=1, seed_in=4'b1001, req=4'b0010 in the same cycle → no gnt that cycle. Next cycle gnt=0010, rnd_out=0011. wrap fires 15 grants later on rnd_out=1001.
- seed_load with seed_in=0 → state loads 0001. The next grant returns 0010, and the LFSR never outputs 0000.
- Idle cycles between requests (req=0 for 5 cycles) → gnt=0, rnd_valid=0, rnd_out unchanged. The next grant continues the sequence with no skipped step.
- rst driven low while req=4'b1111 streams → gnt=0 and rnd_valid=0 at that edge. After release, the first grant goes to req[0] with rnd_out=0010.
